// File: rtl/pmp_pkg.sv
// Shared PMP definitions: cfg byte layout, mode/privilege/access encodings,
// checker FSM states and a permission-select helper.
package pmp_pkg;

  // Address-matching modes held in cfg.a
  localparam logic [1:0] PMP_A_OFF   = 2'd0;
  localparam logic [1:0] PMP_A_TOR   = 2'd1;
  localparam logic [1:0] PMP_A_NA4   = 2'd2;
  localparam logic [1:0] PMP_A_NAPOT = 2'd3;

  // Privilege encodings carried on req_priv
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_U = 2'b00;

  // Access types carried on req_type (2'b11 is reserved and always denied)
  localparam logic [1:0] ACC_READ  = 2'b00;
  localparam logic [1:0] ACC_WRITE = 2'b01;
  localparam logic [1:0] ACC_EXEC  = 2'b10;
  localparam logic [1:0] ACC_RSVD  = 2'b11;

  // One pmpcfg byte, MSB first
  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } pmp_chk_state_e;

  // Permission bit of an entry selected by the access type
  function automatic logic perm_bit(input pmp_cfg_t cfg, input logic [1:0] acc);
    logic p;
    case (acc)
      ACC_READ:  p = cfg.r;
      ACC_WRITE: p = cfg.w;
      ACC_EXEC:  p = cfg.x;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match for a single PMP entry (OFF/TOR/NA4/NAPOT).
// All comparisons are on 32-bit word addresses, unsigned.
module pmp_entry_match
  import pmp_pkg::*;
(
  input  logic [31:0] wa,
  input  pmp_cfg_t    cfg,
  input  logic [31:0] addr_i,
  input  logic [31:0] addr_im1,
  input  logic        i_is_zero,
  output logic        match
);

  logic [31:0] lo;
  logic [31:0] napot_mask;

  // Decode the entry's matching mode against the word address
  always_comb begin
    lo         = i_is_zero ? 32'd0 : addr_im1;
    // Trailing ones of addr_i plus the first zero form the don't-care mask;
    // all-ones addr_i gives an all-ones mask and matches everything.
    napot_mask = addr_i ^ (addr_i + 32'd1);
    match      = 1'b0;
    case (cfg.a)
      PMP_A_TOR:   match = (lo < addr_i) && (wa >= lo) && (wa < addr_i);
      PMP_A_NA4:   match = (wa == addr_i);
      PMP_A_NAPOT: match = ((wa & ~napot_mask) == (addr_i & ~napot_mask));
      default:     match = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_checker.sv
// PMP access checker: captures a request plus a shadow copy of the PMP CSRs,
// scans the 16 entries ENTRIES_PER_CYCLE at a time with lowest-index priority,
// and returns fault/match/entry through a valid/ready response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, holds with stable payload until that edge.
//
// Build option PMP_EARLY_EXIT_EN: when defined, the scan stops after the first
// group that contains a match; when undefined every group is always scanned so
// latency does not depend on the configuration. Results are identical.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [127:0]   pmpcfg_flat,
  input  logic [511:0]   pmpaddr_flat,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [31:0]    req_addr,
  input  logic [1:0]     req_type,
  input  logic [1:0]     req_priv,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_fault,
  output logic           resp_match,
  output logic [3:0]     resp_entry,
  output pmp_chk_state_e dbg_state
);

  localparam int E  = ENTRIES_PER_CYCLE;
  localparam int NG = 16 / E;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [GW-1:0] LAST_G = GW'(NG - 1);

  pmp_chk_state_e state;
  logic [GW-1:0]  g;
  logic           done;
  logic           grant_acc;

  pmp_cfg_t       sh_cfg  [16];
  logic [31:0]    sh_addr [16];
  logic [31:0]    sh_wa;
  logic [1:0]     sh_type;
  logic [1:0]     sh_priv;

  logic [E-1:0]   hit_v;
  logic [3:0]     idx_v [E];

  logic           grp_hit;
  logic [3:0]     grp_idx;
  logic           grp_grant;
  logic           scan_last;
  logic           final_fault;

  assign req_ready = (state == ST_IDLE);
  assign dbg_state = state;

  // One matcher per lane; lane j looks at entry g*E + j of the shadow copy
  for (genvar j = 0; j < E; j++) begin : g_lane
    // Entry index handled by this lane in the current group
    always_comb idx_v[j] = 4'(int'(g) * E + j);

    pmp_entry_match u_match (
      .wa        (sh_wa),
      .cfg       (sh_cfg[idx_v[j]]),
      .addr_i    (sh_addr[idx_v[j]]),
      .addr_im1  (sh_addr[idx_v[j] - 4'd1]),
      .i_is_zero (idx_v[j] == 4'd0),
      .match     (hit_v[j])
    );
  end

  // Lowest-index hit within the group and whether it grants the access
  always_comb begin
    grp_hit   = 1'b0;
    grp_idx   = 4'd0;
    grp_grant = 1'b0;
    for (int j = E - 1; j >= 0; j--) begin
      if (hit_v[j]) begin
        grp_hit   = 1'b1;
        grp_idx   = idx_v[j];
        grp_grant = ((sh_priv == PRIV_M) && !sh_cfg[idx_v[j]].l) ||
                    perm_bit(sh_cfg[idx_v[j]], sh_type);
      end
    end
  end

  // Scan termination: last group always, first matching group if enabled
`ifdef PMP_EARLY_EXIT_EN
  assign scan_last = grp_hit || (g == LAST_G);
`else
  assign scan_last = (g == LAST_G);
`endif

  // Final verdict once the scan is complete; reserved access type always faults
  assign final_fault = (sh_type == ACC_RSVD) ||
                       (resp_match ? !grant_acc : (sh_priv != PRIV_M));

  // Request capture, group-by-group scan and response hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      g          <= '0;
      done       <= 1'b0;
      grant_acc  <= 1'b0;
      sh_wa      <= 32'd0;
      sh_type    <= 2'd0;
      sh_priv    <= 2'd0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_match <= 1'b0;
      resp_entry <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        sh_cfg[i]  <= '0;
        sh_addr[i] <= 32'd0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            for (int i = 0; i < 16; i++) begin
              sh_cfg[i]  <= pmp_cfg_t'(pmpcfg_flat[8*i +: 8]);
              sh_addr[i] <= pmpaddr_flat[32*i +: 32];
            end
            sh_wa      <= {2'b00, req_addr[31:2]};
            sh_type    <= req_type;
            sh_priv    <= req_priv;
            g          <= '0;
            done       <= 1'b0;
            grant_acc  <= 1'b0;
            resp_match <= 1'b0;
            resp_entry <= 4'd0;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!done) begin
            // Only the first matching group is recorded
            if (grp_hit && !resp_match) begin
              resp_match <= 1'b1;
              resp_entry <= grp_idx;
              grant_acc  <= grp_grant;
            end
            if (scan_last) done <= 1'b1;
            else           g    <= g + GW'(1);
          end else begin
            resp_fault <= final_fault;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_checker.sv
// Directed bench for pmp_checker: driver tasks push expected responses into a
// queue, an independent monitor pops and compares when a response appears.
module tb_pmp_checker;
  import pmp_pkg::*;

  localparam int E  = 4;
  localparam int NG = 16 / E;
  localparam int W  = 10;  // {fault, match, entry[3:0], latency[3:0]}

  logic           clock = 1'b0;
  logic           reset;
  logic [127:0]   pmpcfg_flat;
  logic [511:0]   pmpaddr_flat;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_addr;
  logic [1:0]     req_type;
  logic [1:0]     req_priv;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_fault;
  logic           resp_match;
  logic [3:0]     resp_entry;
  pmp_chk_state_e dbg_state;

  pmp_checker #(.ENTRIES_PER_CYCLE(E)) dut (
    .clock        (clock),
    .reset        (reset),
    .pmpcfg_flat  (pmpcfg_flat),
    .pmpaddr_flat (pmpaddr_flat),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_type     (req_type),
    .req_priv     (req_priv),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_fault   (resp_fault),
    .resp_match   (resp_match),
    .resp_entry   (resp_entry),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur (t=%0t)", name, $time);
  endtask

  function automatic int exp_lat(input logic m, input logic [3:0] e);
`ifdef PMP_EARLY_EXIT_EN
    return m ? (int'(e) / E + 2) : (NG + 1);
`else
    return NG + 1;
`endif
  endfunction

  // ---------------- monitor ----------------
  int           acc_cyc = 0;
  bit           seen    = 0;
  logic [W-1:0] mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      seen = 0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc + 1;
      if (resp_valid && !seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_fault", {31'd0, resp_fault}, {31'd0, mon_e[9]});
          chk("resp_match", {31'd0, resp_match}, {31'd0, mon_e[8]});
          chk("resp_entry", {28'd0, resp_entry}, {28'd0, mon_e[7:4]});
          chk("latency", cyc - acc_cyc, {28'd0, mon_e[3:0]});
        end
      end
      if (resp_valid && resp_ready) seen = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
    pmpcfg_flat[8*i +: 8]   = c;
    pmpaddr_flat[32*i +: 32] = a;
  endtask

  task automatic clear_all();
    pmpcfg_flat  = '0;
    pmpaddr_flat = '0;
  endtask

  // Present one request and return just after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [1:0] t, input logic [1:0] p,
                       input logic f, input logic m, input logic [3:0] e, input bit push);
    bit ok;
    logic [3:0] lv;
    lv = 4'(exp_lat(m, e));
    if (push) exp_q.push_back({f, m, e, lv});
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock); #1;
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("req_ready_wait");
    req_addr  = a;
    req_type  = t;
    req_priv  = p;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response handshake edge
  task automatic finish_resp();
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (resp_valid && resp_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("resp_handshake_wait");
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] t, input logic [1:0] p,
                      input logic f, input logic m, input logic [3:0] e);
    issue(a, t, p, f, m, e, 1'b1);
    finish_resp();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'd0;
    req_type     = 2'd0;
    req_priv     = 2'd0;
    resp_ready   = 1'b1;
    pmpcfg_flat  = '0;
    pmpaddr_flat = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_resp_match", {31'd0, resp_match}, 32'd0);
    chk("rst_resp_entry", {28'd0, resp_entry}, 32'd0);
    chk("rst_state",      {30'd0, dbg_state},  {30'd0, ST_IDLE});
    reset = 1'b1;

    // No entries configured: only M-mode is granted
    send(32'h8000_0000, ACC_READ, PRIV_U, 1'b1, 1'b0, 4'd0);
    send(32'h8000_0000, ACC_READ, PRIV_M, 1'b0, 1'b0, 4'd0);

    // Entry 0 NAPOT 0x8000_0000..0x8000_0FFF, read-only
    set_entry(0, 8'h19, 32'h2000_01FF);
    send(32'h8000_0400, ACC_WRITE, PRIV_U, 1'b1, 1'b1, 4'd0);
    send(32'h8000_0400, ACC_READ,  PRIV_U, 1'b0, 1'b1, 4'd0);

    // Entry 5 TOR [0x2000_0000, 0x2000_0100) execute-only
    set_entry(0, 8'h00, 32'h0);
    set_entry(4, 8'h00, 32'h2000_0000);
    set_entry(5, 8'h0C, 32'h2000_0100);
    send(32'h8000_03FC, ACC_EXEC, PRIV_U, 1'b0, 1'b1, 4'd5);
    send(32'h8000_0400, ACC_EXEC, PRIV_U, 1'b1, 1'b0, 4'd0);
    send(32'h8000_0000, ACC_EXEC, PRIV_U, 1'b0, 1'b1, 4'd5);
    send(32'h8000_03FC, ACC_READ, PRIV_U, 1'b1, 1'b1, 4'd5);

    // Locked NA4 entry 2 denies M; permissive entry 1 on the same word wins
    clear_all();
    set_entry(2, 8'h90, 32'h0000_0400);
    send(32'h0000_1000, ACC_READ, PRIV_M, 1'b1, 1'b1, 4'd2);
    set_entry(1, 8'h17, 32'h0000_0400);
    send(32'h0000_1000, ACC_READ, PRIV_M, 1'b0, 1'b1, 4'd1);
    send(32'h0000_1000, ACC_RSVD, PRIV_M, 1'b1, 1'b1, 4'd1);

    // TOR at entry 0 uses 0 as lower bound; inverted TOR range never matches
    clear_all();
    set_entry(0, 8'h09, 32'h0000_0100);
    send(32'h0000_0000, ACC_READ, PRIV_U, 1'b0, 1'b1, 4'd0);
    send(32'h0000_0400, ACC_READ, PRIV_U, 1'b1, 1'b0, 4'd0);
    set_entry(2, 8'h00, 32'h0000_0400);
    set_entry(3, 8'h09, 32'h0000_0300);
    send(32'h0000_0800, ACC_READ, PRIV_U, 1'b1, 1'b0, 4'd0);

    // All-ones NAPOT on the last entry covers everything
    clear_all();
    set_entry(15, 8'h1F, 32'hFFFF_FFFF);
    send(32'h1234_5678, ACC_WRITE, PRIV_U, 1'b0, 1'b1, 4'd15);

    // Response held with resp_ready low
    resp_ready = 1'b0;
    issue(32'hDEAD_BEEC, ACC_EXEC, PRIV_U, 1'b0, 1'b1, 4'd15, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (resp_valid) break;
    end
    repeat (10) begin
      @(negedge clock);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_fault", {31'd0, resp_fault}, 32'd0);
      chk("hold_match", {31'd0, resp_match}, 32'd1);
      chk("hold_entry", {28'd0, resp_entry}, 32'd15);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    finish_resp();

    // CSR changes after acceptance are not seen by the scan
    issue(32'h4000_0000, ACC_READ, PRIV_U, 1'b0, 1'b1, 4'd15, 1'b1);
    set_entry(15, 8'h00, 32'h0);
    finish_resp();
    set_entry(15, 8'h1F, 32'hFFFF_FFFF);

    // Reset in the middle of a scan drops the request
    issue(32'h0000_2000, ACC_READ, PRIV_U, 1'b0, 1'b1, 4'd15, 1'b0);
    reset = 1'b0;
    #1;
    chk("scan_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("scan_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    end
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Normal operation resumes
    send(32'h0000_0000, ACC_READ, PRIV_M, 1'b0, 1'b1, 4'd15);

    repeat (3) @(posedge clock);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pmp_checker.md
# pmp_checker

Consumer side of the PMP CSR file: takes the live `pmpcfg`/`pmpaddr` values and decides whether a physical access may proceed. Each accepted request is scanned over 16 entries, ENTRIES_PER_CYCLE at a time, with lowest-index-match priority. The result is returned through a valid/ready response. Sits between the load/store/fetch units and the memory interface.

## Interface
- ENTRIES_PER_CYCLE, 4, entries evaluated per SCAN cycle; must divide 16.
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pmpcfg_flat  input  128  {pmpcfg3,pmpcfg2,pmpcfg1,pmpcfg0}; entry i cfg = bits [8i+7:8i].
- pmpaddr_flat  input  512  {pmpaddr15..pmpaddr0}; entry i = bits [32i+31:32i].
- req_valid  input  1  request present.
- req_ready  output  1  checker can accept.
- req_addr  input  32  physical byte address.
- req_type  input  2  00 read, 01 write, 10 execute, 11 reserved.
- req_priv  input  2  11 M, 01 S, 00 U.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_fault  output  1  1 = access denied.
- resp_match  output  1  1 = some entry matched.
- resp_entry  output  4  lowest matching entry index (0 if none).

## Operation
- Cfg byte fields: R[0], W[1], X[2], A[4:3] (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), L[7].
- Word address wa = {2'b00, req_addr[31:2]}; all comparisons are 32-bit unsigned.
- OFF: never matches.
- TOR: match iff lo ≤ wa < pmpaddr[i]; lo = pmpaddr[i-1], or 0 for i=0; lo ≥ hi → no match.
- NA4: match iff wa == pmpaddr[i].
- NAPOT: m = pmpaddr[i] ^ (pmpaddr[i]+1); match iff (wa & ~m) == (pmpaddr[i] & ~m). All-ones matches every address.
- Permission bit selected by req_type: R, W or X.
- Matched entry: grant if req_priv==M && L==0; otherwise grant iff permission bit = 1.
- No match: grant iff req_priv==M.
- req_type==11: always fault, regardless of match.
- On acceptance, request fields and both flat config buses are captured into shadow registers. CSR writes during a scan do not affect the result.
- FSM states:
  - IDLE: req_ready=1; on req_valid go to SCAN, group counter g=0.
  - SCAN: evaluate entries [g·E, g·E+E-1] against shadow. On match (early exit) or last group, latch result and go to RESP; else g++.
  - RESP: resp_valid=1, outputs stable. On resp_ready go to IDLE.
- Earlier groups take priority; within a group the lowest index wins.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_match=0, resp_entry=0, g=0.
- req_ready is 1 only in IDLE; it is a decode of the state register.
- Request accepted at edge 0. Group k is evaluated in the cycle after edge k. resp_valid rises at edge k+2, where k is the deciding group.
- Minimum latency 2 cycles (match in group 0). Maximum latency 1 + 16/E cycles (5 cycles at E=4).
- Response is held while resp_ready=0. The handshake edge returns to IDLE; the next request is accepted no earlier than the following edge.
- Reset asserted mid-SCAN or mid-RESP: immediate return to IDLE, pending request discarded, no response.

## Configuration
- PMP_EARLY_EXIT_EN defined: SCAN terminates on the first group containing a match.
- PMP_EARLY_EXIT_EN undefined: all 16/E groups are always scanned and the first match is recorded. Latency is fixed at 1 + 16/E cycles (timing-side-channel-free). Result values are identical in both builds.

## Structure
- Shared package `pmp_pkg`:
  - constants PMP_A_OFF/TOR/NA4/NAPOT, PRIV_M/S/U, ACC_READ/WRITE/EXEC;
  - typedef `pmp_cfg_t` (packed struct L, rsvd[1:0], A[1:0], X, W, R);
  - state enum `pmp_chk_state_e`.
- One sub-module `pmp_entry_match`: combinational single-entry match (inputs wa, cfg, addr_i, addr_im1, i_is_zero; output match). Instantiated ENTRIES_PER_CYCLE times with a group-indexed mux.

## Test plan
- Reset, then all cfg=0, U-mode read of 0x8000_0000 → resp_match=0, resp_fault=1. Same request in M-mode → resp_fault=0.
- Entry 0 NAPOT: pmpaddr0=0x2000_01FF, cfg R=1 W=0. U write 0x8000_0400 → match, entry 0, fault=1. U read → fault=0, resp_valid 2 cycles after accept (early exit).
- Entry 5 TOR: pmpaddr4=0x2000_0000, pmpaddr5=0x2000_0100, X=1. Exec 0x8000_03FC → entry 5, fault=0. Exec 0x8000_0400 → no match, fault=1.
- L=1 entry 2 NA4 at 0x1000 with R=0; M-mode read 0x1000 → fault=1. Overlapping lower entry 1 permissive → entry 1 wins, fault=0.
- Hold resp_ready=0 for 10 cycles → resp fields stable, req_ready=0. Assert reset during SCAN → resp_valid never rises, req_ready=1 after reset.
- Without PMP_EARLY_EXIT_EN, any request → resp_valid exactly 5 cycles after accept.
